// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave between an instruction-fetch
// master and a MEM-stage data master, one outstanding transaction at a time.
//
// Ports:
//   clk, resetn                   clock and synchronous active-low reset
//   inst_req/wr/size/addr/wdata   fetch master request (read only)
//   inst_addr_ok/data_ok/rdata    fetch master handshake and read data
//   inst_cancel                   flush pulse; discards the fetch in flight
//   data_req/wr/size/addr/wdata   MEM-stage master request
//   data_addr_ok/data_ok/rdata    MEM-stage master handshake and read data
//   sram_req/wr/size/addr/wdata   shared slave request
//   sram_addr_ok/data_ok/rdata    shared slave handshake and read data
module sram_like_arbiter (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_d;
    logic   owner, owner_d;      // 1 = data master owns the slave
    logic   wr_q, wr_d;          // owner's transaction is a write
    logic   discard, discard_d;  // cancelled fetch: swallow its response
    logic   sel_valid, sel_data, done;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= 1'b0;
            wr_q    <= 1'b0;
            discard <= 1'b0;
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            wr_q    <= wr_d;
            discard <= discard_d;
        end
    end

    // Selection, slave forwarding, response routing and next state
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        wr_d         = wr_q;
        discard_d    = discard;
        sel_valid    = 1'b0;
        sel_data     = 1'b0;
        done         = 1'b0;
        sram_req     = 1'b0;
        sram_wr      = 1'b0;
        sram_size    = 2'b0;
        sram_addr    = 32'b0;
        sram_wdata   = 32'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'b0;
        data_rdata   = 32'b0;

        // Outputs stay quiet while reset is asserted
        if (resetn) begin
            case (state)
                IDLE: begin
                    sel_valid = data_req | inst_req;
                    sel_data  = data_req;
                end
                ADDR: begin
                    sel_data  = owner;
                    sel_valid = owner ? data_req : inst_req;
                end
                DATA: done = sram_data_ok;
                default: ;
            endcase

            if (sel_valid) begin
                sram_req = 1'b1;
                if (sel_data) begin
                    sram_wr    = data_wr;
                    sram_size  = data_size;
                    sram_addr  = data_addr;
                    sram_wdata = data_wdata;
                end else begin
                    sram_wr    = inst_wr;
                    sram_size  = inst_size;
                    sram_addr  = inst_addr;
                    sram_wdata = inst_wdata;
                end
                inst_addr_ok = !sel_data && sram_addr_ok;
                data_addr_ok = sel_data && sram_addr_ok;
                owner_d      = sel_data;
                wr_d         = sram_wr;
                state_d      = sram_addr_ok ? DATA : ADDR;
            end

            // Cancel only matters once the fetch owns the slave
            if ((state == ADDR || state == DATA) && !owner && inst_cancel)
                discard_d = 1'b1;

            if (done) begin
                state_d      = IDLE;
                discard_d    = 1'b0;
                data_data_ok = owner;
                inst_data_ok = !owner && !discard && !inst_cancel;
                if (owner && !wr_q)
                    data_rdata = sram_rdata;
                if (inst_data_ok)
                    inst_rdata = sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenarios plus a randomized run checked
// against a queue-based transaction model of the arbiter.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        sram_req, sram_wr, sram_addr_ok, sram_data_ok;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic is_data;
        logic wr;
        logic discard;
    } txn_t;

    always #5 clk = ~clk;

    sram_like_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_cancel  (inst_cancel),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_req     (sram_req),
        .sram_wr      (sram_wr),
        .sram_size    (sram_size),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_addr_ok (sram_addr_ok),
        .sram_data_ok (sram_data_ok),
        .sram_rdata   (sram_rdata)
    );

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        data_req = 1; data_addr = 32'h8000_0000; inst_req = 1; inst_addr = 32'hBFC0_0000;
        sram_addr_ok = 1; sram_data_ok = 1; sram_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        n_checks++; if (sram_req !== 1'b0) begin n_fail++; $display("FAIL rst_sram_req got=%0b exp=0", sram_req); end
        n_checks++; if (data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_addr_ok got=%0b%0b exp=00", data_addr_ok, inst_addr_ok); end
        n_checks++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_ok got=%0b%0b exp=00", data_data_ok, inst_data_ok); end
        n_checks++; if (data_rdata !== 32'h0 || sram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_buses got=%h/%h exp=0/0", data_rdata, sram_addr); end
        resetn = 1;
        idle_inputs();
        #1;
        n_checks++; if (sram_req !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL post_rst_quiet got=%0b%0b exp=00", sram_req, data_data_ok); end
        data_req = 1; data_addr = 32'h8000_0004; #1;
        n_checks++; if (sram_req !== 1'b1 || sram_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL post_rst_req got=%0b/%h exp=1/80000004", sram_req, sram_addr); end
        data_req = 0;
        next_cycle();
    endtask

    task automatic test_tie();
        idle_inputs();
        data_req = 1; data_addr = 32'h8000_0010; inst_req = 1; inst_addr = 32'hBFC0_0000; sram_addr_ok = 1; #1;
        n_checks++; if (sram_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL tie_addr got=%h exp=80000010", sram_addr); end
        n_checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL tie_aok got=d%0b i%0b exp=d1 i0", data_addr_ok, inst_addr_ok); end
        next_cycle();
        data_req = 0; #1;
        n_checks++; if (sram_req !== 1'b0) begin n_fail++; $display("FAIL tie_data_phase_req got=%0b exp=0", sram_req); end
        sram_data_ok = 1; sram_rdata = 32'h0000_1111; #1;
        n_checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h1111 || inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL tie_resp got=%0b/%h/%0b exp=1/00001111/0", data_data_ok, data_rdata, inst_data_ok); end
        n_checks++; if (sram_req !== 1'b0) begin n_fail++; $display("FAIL tie_no_fwd_on_resp got=%0b exp=0", sram_req); end
        next_cycle();
        sram_data_ok = 0; #1;
        n_checks++; if (sram_addr !== 32'hBFC0_0000 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL tie_inst_next got=%h/%0b/%0b exp=bfc00000/1/0", sram_addr, inst_addr_ok, data_addr_ok); end
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h0000_2222; #1;
        n_checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h2222) begin n_fail++; $display("FAIL tie_inst_resp got=%0b/%h exp=1/00002222", inst_data_ok, inst_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lock();
        idle_inputs();
        inst_req = 1; inst_addr = 32'hBFC0_0004; #1;
        n_checks++; if (sram_addr !== 32'hBFC0_0004 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_c1 got=%h/%0b exp=bfc00004/0", sram_addr, inst_addr_ok); end
        next_cycle();
        data_req = 1; data_addr = 32'h8000_0020; #1;
        n_checks++; if (sram_req !== 1'b1 || sram_addr !== 32'hBFC0_0004 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_c2 got=%0b/%h/%0b exp=1/bfc00004/0", sram_req, sram_addr, data_addr_ok); end
        next_cycle(); #1;
        n_checks++; if (sram_addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL lock_c3 got=%h exp=bfc00004", sram_addr); end
        next_cycle();
        sram_addr_ok = 1; #1;
        n_checks++; if (sram_addr !== 32'hBFC0_0004 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_accept got=%h/%0b/%0b exp=bfc00004/1/0", sram_addr, inst_addr_ok, data_addr_ok); end
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h33; #1;
        n_checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL lock_resp got=i%0b d%0b exp=i1 d0", inst_data_ok, data_data_ok); end
        next_cycle();
        sram_data_ok = 0; sram_addr_ok = 1; #1;
        n_checks++; if (sram_addr !== 32'h8000_0020 || data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL lock_data_next got=%h/%0b exp=80000020/1", sram_addr, data_addr_ok); end
        next_cycle();
        data_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h44; #1;
        n_checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h44) begin n_fail++; $display("FAIL lock_data_resp got=%0b/%h exp=1/00000044", data_data_ok, data_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_read_return();
        idle_inputs();
        data_req = 1; data_addr = 32'h8000_0040; sram_addr_ok = 1; #1;
        n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rr_accept got=%0b exp=1", data_addr_ok); end
        next_cycle();
        data_req = 0; sram_addr_ok = 0; #1;
        n_checks++; if (data_data_ok !== 1'b0 || sram_req !== 1'b0) begin n_fail++; $display("FAIL rr_wait got=%0b/%0b exp=0/0", data_data_ok, sram_req); end
        next_cycle();
        sram_data_ok = 1; sram_rdata = 32'h1234_5678; #1;
        n_checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rr_data got=%0b/%h exp=1/12345678", data_data_ok, data_rdata); end
        n_checks++; if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin n_fail++; $display("FAIL rr_inst_quiet got=%0b/%h exp=0/0", inst_data_ok, inst_rdata); end
        next_cycle();
        sram_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC0_0010; sram_addr_ok = 1; #1;
        n_checks++; if (inst_addr_ok !== 1'b1 || sram_addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL rr_idle_next got=%0b/%h exp=1/bfc00010", inst_addr_ok, sram_addr); end
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h5; #1;
        n_checks++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL rr_inst_resp got=%0b exp=1", inst_data_ok); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_cancel();
        idle_inputs();
        inst_req = 1; inst_addr = 32'hBFC0_0020; sram_addr_ok = 1;
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; inst_cancel = 1; #1;
        n_checks++; if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL cancel_pulse got=%0b exp=0", inst_data_ok); end
        next_cycle();
        inst_cancel = 0; sram_data_ok = 1; sram_rdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin n_fail++; $display("FAIL cancel_resp got=%0b/%h exp=0/0", inst_data_ok, inst_rdata); end
        next_cycle();
        // cancel while idle must not touch the next fetch
        sram_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC0_0024; sram_addr_ok = 1; inst_cancel = 1; #1;
        n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL cancel_idle_accept got=%0b exp=1", inst_addr_ok); end
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; inst_cancel = 0; sram_data_ok = 1; sram_rdata = 32'h0BAD_F00D; #1;
        n_checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL cancel_next_resp got=%0b/%h exp=1/0badf00d", inst_data_ok, inst_rdata); end
        next_cycle();
        sram_data_ok = 0; inst_req = 1; sram_addr_ok = 1;
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; inst_cancel = 1; sram_rdata = 32'h77; #1;
        n_checks++; if (inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL cancel_same_cycle got=%0b exp=0", inst_data_ok); end
        next_cycle();
        idle_inputs();
        data_req = 1; data_addr = 32'h8000_0060; sram_addr_ok = 1;
        next_cycle();
        data_req = 0; sram_addr_ok = 0; inst_cancel = 1; sram_data_ok = 1; sram_rdata = 32'h99; #1;
        n_checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h99) begin n_fail++; $display("FAIL cancel_data_owner got=%0b/%h exp=1/00000099", data_data_ok, data_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        data_req = 1; data_addr = 32'h8000_0080; sram_addr_ok = 1;
        next_cycle();
        data_req = 0; sram_addr_ok = 0; resetn = 0; #1;
        n_checks++; if (data_data_ok !== 1'b0 || sram_req !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet got=%0b/%0b exp=0/0", data_data_ok, sram_req); end
        next_cycle();
        resetn = 1; sram_data_ok = 1; sram_rdata = 32'h55; #1;
        n_checks++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0 || data_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_stray got=%0b/%0b/%h exp=0/0/0", data_data_ok, inst_data_ok, data_rdata); end
        n_checks++; if (sram_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got=%0b exp=0", sram_req); end
        next_cycle();
        inst_req = 1; inst_addr = 32'hBFC0_0030; #1;
        n_checks++; if (sram_req !== 1'b1 || sram_addr !== 32'hBFC0_0030 || inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL midrst_new_req got=%0b/%h/%0b exp=1/bfc00030/0", sram_req, sram_addr, inst_data_ok); end
        next_cycle();
        sram_addr_ok = 1; #1;
        n_checks++; if (inst_data_ok !== 1'b0 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL spurious_in_addr got=%0b/%0b exp=0/1", inst_data_ok, inst_addr_ok); end
        next_cycle();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h66; #1;
        n_checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h66) begin n_fail++; $display("FAIL midrst_resp got=%0b/%h exp=1/00000066", inst_data_ok, inst_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_write();
        idle_inputs();
        data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_0100; data_wdata = 32'hA5A5_A5A5; sram_addr_ok = 1; #1;
        n_checks++; if (sram_wr !== 1'b1 || sram_wdata !== 32'hA5A5_A5A5 || sram_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL wr_fwd got=%0b/%h/%h exp=1/a5a5a5a5/80000100", sram_wr, sram_wdata, sram_addr); end
        next_cycle();
        data_req = 0; data_wr = 0; sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'hFFFF_FFFF; #1;
        n_checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_done got=%0b/%h exp=1/0", data_data_ok, data_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        txn_t        pend[$];
        txn_t        t;
        int          lock;
        logic        lock_discard;
        logic        i_act, d_act, d_wr;
        logic [1:0]  d_size;
        logic [31:0] i_addr, d_addr, d_wdata;
        int          sel;
        logic        busy, exp_req, exp_wr, exp_iaok, exp_daok, exp_iok, exp_dok;
        logic [31:0] exp_addr, exp_ird, exp_drd;

        idle_inputs();
        resetn = 0;
        next_cycle();
        resetn = 1;
        lock = -1; lock_discard = 0;
        i_act = 0; d_act = 0; d_wr = 0; d_size = 0; i_addr = 0; d_addr = 0; d_wdata = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_wr = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
                d_addr = $urandom; d_wdata = $urandom;
            end
            inst_req = i_act; inst_addr = i_addr; inst_wr = 0; inst_size = 2'd2;
            data_req = d_act; data_wr = d_wr; data_size = d_size; data_addr = d_addr; data_wdata = d_wdata;
            sram_addr_ok = ($urandom_range(0, 2) != 0);
            sram_data_ok = ($urandom_range(0, 2) == 0);
            sram_rdata   = $urandom;
            inst_cancel  = ($urandom_range(0, 9) == 0);
            #1;

            // At most one transaction may be outstanding; a locked master keeps priority
            busy = (pend.size() != 0);
            sel = -1;
            if (!busy) sel = (lock >= 0) ? lock : (d_act ? 1 : (i_act ? 0 : -1));
            exp_req  = (sel >= 0);
            exp_addr = (sel == 1) ? d_addr : ((sel == 0) ? i_addr : 32'h0);
            exp_wr   = (sel == 1) ? d_wr : 1'b0;
            exp_iaok = (sel == 0) && sram_addr_ok;
            exp_daok = (sel == 1) && sram_addr_ok;
            exp_iok = 0; exp_dok = 0; exp_ird = 0; exp_drd = 0;
            if (busy && sram_data_ok) begin
                if (pend[0].is_data) begin
                    exp_dok = 1; exp_drd = pend[0].wr ? 32'h0 : sram_rdata;
                end else if (!pend[0].discard && !inst_cancel) begin
                    exp_iok = 1; exp_ird = sram_rdata;
                end
            end

            n_checks++; if (sram_req !== exp_req) begin n_fail++; $display("FAIL rnd_sram_req cyc=%0d got=%0b exp=%0b", cyc, sram_req, exp_req); end
            n_checks++; if (sram_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_sram_addr cyc=%0d got=%h exp=%h", cyc, sram_addr, exp_addr); end
            n_checks++; if (sram_wr !== exp_wr) begin n_fail++; $display("FAIL rnd_sram_wr cyc=%0d got=%0b exp=%0b", cyc, sram_wr, exp_wr); end
            n_checks++; if (inst_addr_ok !== exp_iaok) begin n_fail++; $display("FAIL rnd_inst_addr_ok cyc=%0d got=%0b exp=%0b", cyc, inst_addr_ok, exp_iaok); end
            n_checks++; if (data_addr_ok !== exp_daok) begin n_fail++; $display("FAIL rnd_data_addr_ok cyc=%0d got=%0b exp=%0b", cyc, data_addr_ok, exp_daok); end
            n_checks++; if (inst_data_ok !== exp_iok) begin n_fail++; $display("FAIL rnd_inst_data_ok cyc=%0d got=%0b exp=%0b", cyc, inst_data_ok, exp_iok); end
            n_checks++; if (data_data_ok !== exp_dok) begin n_fail++; $display("FAIL rnd_data_data_ok cyc=%0d got=%0b exp=%0b", cyc, data_data_ok, exp_dok); end
            n_checks++; if (inst_rdata !== exp_ird) begin n_fail++; $display("FAIL rnd_inst_rdata cyc=%0d got=%h exp=%h", cyc, inst_rdata, exp_ird); end
            n_checks++; if (data_rdata !== exp_drd) begin n_fail++; $display("FAIL rnd_data_rdata cyc=%0d got=%h exp=%h", cyc, data_rdata, exp_drd); end

            if (busy) begin
                t = pend[0];
                if (inst_cancel && !t.is_data) t.discard = 1;
                pend[0] = t;
                if (sram_data_ok) void'(pend.pop_front());
            end else if (sel >= 0) begin
                if (lock == 0 && inst_cancel) lock_discard = 1;
                if (sram_addr_ok) begin
                    t.is_data = (sel == 1); t.wr = exp_wr; t.discard = lock_discard;
                    pend.push_back(t);
                    lock = -1; lock_discard = 0;
                end else begin
                    lock = sel;
                end
            end
            if (exp_iaok) i_act = 0;
            if (exp_daok) d_act = 0;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_lock();
        test_read_return();
        test_cancel();
        test_reset_midop();
        test_write();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter: none; all widths are fixed as listed below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 inst_req / inst_wr / inst_size / inst_addr / inst_wdata  in  1/1/2/32/32  instruction-fetch master request; inst_wr is always 0.
REQ-005 inst_addr_ok / inst_data_ok  out  1/1  address accepted / read data valid to fetch; inst_rdata  out  32.
REQ-006 inst_cancel  in  1  pulse; the fetch response in flight is discarded (exception/ERET flush).
REQ-007 data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  MEM-stage master request.
REQ-008 data_addr_ok / data_data_ok  out  1/1; data_rdata  out  32.
REQ-009 sram_req / sram_wr / sram_size / sram_addr / sram_wdata  out  1/1/2/32/32  shared slave request.
REQ-010 sram_addr_ok / sram_data_ok  in  1/1; sram_rdata  in  32.

Function
REQ-011 The block SHALL keep at most one slave transaction outstanding; FSM states: IDLE, ADDR, DATA.
REQ-012 IDLE: when data_req=1 the data master SHALL be selected; else when inst_req=1 the inst master; data always wins a same-cycle tie.
REQ-013 In IDLE and ADDR, sram_req and sram_wr/size/addr/wdata SHALL be driven combinationally from the selected (IDLE) or locked (ADDR) master; with no selection, sram_req=0.
REQ-014 The selected master's addr_ok SHALL equal sram_addr_ok combinationally; the other master's addr_ok SHALL be 0.
REQ-015 IDLE, sram_req=1, sram_addr_ok=0 -> ADDR, owner registered; the owner SHALL stay locked until sram_addr_ok, even if the other master raises req.
REQ-016 IDLE or ADDR with sram_req=1 and sram_addr_ok=1 -> DATA, owner registered; sram_req SHALL be 0 throughout DATA.
REQ-017 DATA, sram_data_ok=1 -> IDLE; the owner's data_ok SHALL be 1 that cycle with its rdata = sram_rdata (combinational, zero latency); in the same cycle no new request SHALL be forwarded.
REQ-018 Non-owner data_ok SHALL be 0 at all times; inst_rdata/data_rdata SHALL be 32'b0 when their data_ok is 0.
REQ-019 inst_cancel=1 while owner=inst in ADDR or DATA SHALL set a discard flag; the inst transaction still completes on the slave, but inst_data_ok SHALL stay 0 for it; flag clears on that sram_data_ok.
REQ-020 inst_cancel in IDLE, or while owner=data, SHALL have no effect; inst_cancel in the same cycle as the inst sram_data_ok SHALL suppress that inst_data_ok.
REQ-021 sram_data_ok in IDLE or ADDR (spurious) SHALL be ignored: no data_ok raised, no state change.
REQ-022 Writes (data_wr=1) SHALL follow the same FSM; data_data_ok marks write completion and data_rdata=0.
REQ-023 Throughput: back-to-back accepted transactions SHALL be spaced at least 2 cycles (accept, then response cycle returns to IDLE).

Reset
REQ-024 resetn=0 at a rising edge SHALL force IDLE, clear owner and discard flag, independent of any transaction in progress.
REQ-025 While in reset and the first cycle after, all outputs SHALL be 0 unless a master requests in that first cycle (REQ-013 applies).
REQ-026 A slave response arriving after reset for a pre-reset transaction SHALL be ignored per REQ-021.

Verification
REQ-027 Tie: data_req=1 addr 0x8000_0010, inst_req=1 addr 0xBFC0_0000, same cycle, addr_ok=1 -> sram_addr=0x8000_0010, data_addr_ok=1, inst_addr_ok=0; inst served next in IDLE.
REQ-028 Lock: inst_req at 0xBFC0_0004 with addr_ok held 0 for 3 cycles, data_req rises cycle 2 -> sram_addr stays 0xBFC0_0004 until addr_ok; data waits.
REQ-029 Read return: data read accepted, sram_data_ok=1 with rdata 0x1234_5678 two cycles later -> data_data_ok=1, data_rdata=0x1234_5678, inst_data_ok=0, state IDLE next cycle.
REQ-030 Cancel: inst read in DATA, inst_cancel pulse, then sram_data_ok with 0xDEAD_BEEF -> inst_data_ok=0 throughout; following inst read returns normally.
REQ-031 Reset mid-op: resetn=0 for 1 cycle while in DATA, then stray sram_data_ok -> no data_ok asserted, sram_req follows new requests only.
REQ-032 Write: data_wr=1, wdata 0xA5A5_A5A5, addr 0x8000_0100 -> sram_wr=1, sram_wdata=0xA5A5_A5A5; data_data_ok=1 with data_rdata=0 on completion.
